// File: rtl/frame_buf_scan_reader_if.sv
// frame_buf_scan_reader_if: frame-buffer read port between the scan reader and the pixel memory
interface frame_buf_scan_reader_if;
    logic [14:0] rd_addr;
    logic        rd_en;
    logic [23:0] rd_data;
    modport master (output rd_addr, rd_en, input rd_data);
    modport slave (input rd_addr, rd_en, output rd_data);
endinterface

// File: rtl/frame_buf_scan_reader.sv
// frame_buf_scan_reader: turns the VGA raster position into frame-buffer reads and aligns returned pixels
module frame_buf_scan_reader #(
    parameter int          RD_LATENCY  = 2,
    parameter int          VIRT_W      = 160,
    parameter int          VIRT_H      = 120,
    parameter int          PIX_SHIFT   = 2,
    parameter logic [23:0] BLANK_COLOR = 24'h000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    active_pixels,
    input  logic                    frame_done,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    frame_buf_scan_reader_if.master fb,
    output logic [23:0]             pixel_rgb,
    output logic                    pixel_valid,
    output logic                    scanning,
    output logic [18:0]             last_frame_reads
);
    localparam logic [0:0] WAIT_FRAME = 1'b0;
    localparam logic [0:0] SCAN       = 1'b1;
    localparam int SCR_W = VIRT_W << PIX_SHIFT;
    localparam int SCR_H = VIRT_H << PIX_SHIFT;

    logic [0:0]            state;
    logic [RD_LATENCY-1:0] vld;
    logic [18:0]           reads;
    logic [14:0]           vx, vy, addr;
    logic                  hit;

    assign scanning = state == SCAN;
    assign hit = scanning && enable && active_pixels && x < 10'(SCR_W) && y < 10'(SCR_H);
    assign vx = 15'(x >> PIX_SHIFT);
    assign vy = 15'(y >> PIX_SHIFT);
    // row stride of 160 as 128 + 32
    assign addr = (vy << 7) + (vy << 5) + vx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= WAIT_FRAME;
            fb.rd_en         <= 1'b0;
            fb.rd_addr       <= '0;
            vld              <= '0;
            pixel_valid      <= 1'b0;
            pixel_rgb        <= BLANK_COLOR;
            reads            <= '0;
            last_frame_reads <= '0;
        end else begin
            state <= scanning ? (enable ? SCAN : WAIT_FRAME) : (frame_done && enable ? SCAN : WAIT_FRAME);
            fb.rd_en <= hit;
            if (hit)
                fb.rd_addr <= addr;
            vld         <= RD_LATENCY'({vld, fb.rd_en});
            pixel_valid <= vld[RD_LATENCY-1];
            pixel_rgb   <= vld[RD_LATENCY-1] ? fb.rd_data : BLANK_COLOR;
            if (frame_done) begin
                reads <= scanning ? 19'(fb.rd_en) : '0;
                if (scanning)
                    last_frame_reads <= reads + 19'(fb.rd_en);
            end else begin
                reads <= reads + 19'(fb.rd_en);
            end
        end
    end
endmodule
